alu_arbiter: RTL and testbench

//   Two-requester arbiter and sequencer for the shared 8-bit ALU (FORWARD/ADD/AND/OR, SELECT 0-3).

---
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Purpose : two-requester round-robin arbiter/sequencer for a shared combinational ALU.
// Latency : legal op -> response valid SETTLE clocks after accept; bad opcode -> valid right after accept.
// Backpressure: one op in flight; both request READYs held low until the response handshake completes.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   reqN_valid/ready/data1/data2/select  request channel N (N=0,1), accept on valid&ready
//   rspN_valid/ready                response channel N, only the owner's channel is driven
//   rsp_result, rsp_err             shared response payload (err=1 -> unsupported select, result 0)
//   alu_data1/data2/select          registered operands/opcode to the ALU, held between ops
//   alu_result                      combinational ALU output, captured after SETTLE clocks
//   busy                            high whenever an operation is in flight
module alu_arbiter #(
   parameter int WIDTH  = 8,
   parameter int SEL_W  = 3,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_data1,
   input  logic [WIDTH-1:0] req0_data2,
   input  logic [SEL_W-1:0] req0_select,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_data1,
   input  logic [WIDTH-1:0] req1_data2,
   input  logic [SEL_W-1:0] req1_select,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_data1,
   output logic [WIDTH-1:0] alu_data2,
   output logic [SEL_W-1:0] alu_select,
   input  logic [WIDTH-1:0] alu_result,
   output logic             busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_t;

   // count runs SETTLE-1 down to 0; capture happens on the edge where it is 0
   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_t           state;
   logic [3:0]       count;
   logic             owner;
   logic             last;

   logic             grant;
   logic             accept;
   logic             sel_ok;
   logic [WIDTH-1:0] acc_d1;
   logic [WIDTH-1:0] acc_d2;
   logic [SEL_W-1:0] acc_sel;
   logic             owner_rdy;

   // Round-robin: a lone requester wins; on contention the one not served last wins.
   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last;
      end
   end

   // READY is gated by reset so every output reads 0 while rst_n is low.
   assign req0_ready = rst_n && (state == ST_IDLE) && !grant && req0_valid;
   assign req1_ready = rst_n && (state == ST_IDLE) &&  grant && req1_valid;
   assign accept     = req0_ready || req1_ready;

   assign acc_d1  = grant ? req1_data1  : req0_data1;
   assign acc_d2  = grant ? req1_data2  : req0_data2;
   assign acc_sel = grant ? req1_select : req0_select;

   // Opcodes 0..3 are the only ones the ALU implements.
   assign sel_ok = ((acc_sel >> 2) == '0);

   assign rsp0_valid = (state == ST_RESP) && !owner;
   assign rsp1_valid = (state == ST_RESP) &&  owner;
   assign owner_rdy  = owner ? rsp1_ready : rsp0_ready;
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         count      <= '0;
         owner      <= 1'b0;
         last       <= 1'b1;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
         alu_data1  <= '0;
         alu_data2  <= '0;
         alu_select <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  owner <= grant;
                  last  <= grant;
                  if (sel_ok) begin
                     alu_data1  <= acc_d1;
                     alu_data2  <= acc_d2;
                     alu_select <= acc_sel;
                     count      <= CNT_INIT;
                     state      <= ST_SETTLE;
                  end else begin
                     // ALU operands deliberately left alone: no toggling for a rejected op
                     rsp_result <= '0;
                     rsp_err    <= 1'b1;
                     state      <= ST_RESP;
                  end
               end
            end
            ST_SETTLE: begin
               if (count != 4'd0) begin
                  count <= count - 4'd1;
               end else begin
                  rsp_result <= alu_result;
                  rsp_err    <= 1'b0;
                  state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (owner_rdy) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   localparam int WIDTH  = 8;
   localparam int SEL_W  = 3;
   localparam int SETTLE = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_data1, req0_data2, req1_data1, req1_data2;
   logic [SEL_W-1:0] req0_select, req1_select;
   logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_err;
   logic [WIDTH-1:0] alu_data1, alu_data2, alu_result;
   logic [SEL_W-1:0] alu_select;
   logic             busy;

   int n_cmp = 0;
   int n_err = 0;
   int model_last;

   always #5 clk = ~clk;

   // Behavioural arithmetic of the shared ALU.
   function automatic logic [7:0] ref_alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      case (s)
         3'd0:    return b;
         3'd1:    return a + b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         default: return 8'hEE;
      endcase
   endfunction

   assign alu_result = ref_alu(alu_select, alu_data1, alu_data2);

   alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
      .req0_data2(req0_data2), .req0_select(req0_select),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
      .req1_data2(req1_data2), .req1_select(req1_select),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_err(rsp_err),
      .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
      .alu_result(alu_result), .busy(busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return {31'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_err,
              alu_data1, alu_data2, alu_select, busy};
   endfunction

   // One complete transaction, entered and left at #1 after a rising edge with the DUT idle.
   task automatic round(input string tag, input bit v0, input bit v1,
                        input logic [2:0] s0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [2:0] s1, input logic [7:0] a1, input logic [7:0] b1,
                        input bit hold, input int bp,
                        input int e_own, input logic [7:0] e_res, input bit e_err);
      logic [7:0]  pd1, pd2;
      logic [2:0]  psel;
      logic [18:0] exp_alu;
      logic [7:0]  held;
      int          lat;
      req0_valid = v0; req0_select = s0; req0_data1 = a0; req0_data2 = b0;
      req1_valid = v1; req1_select = s1; req1_data1 = a1; req1_data2 = b1;
      pd1 = alu_data1; pd2 = alu_data2; psel = alu_select;
      #1;
      check({tag, " grant"}, {req1_ready, req0_ready}, (e_own == 1) ? 2'b10 : 2'b01);
      if (!(req0_ready || req1_ready)) begin
         req0_valid = 1'b0; req1_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (!hold) begin
         req0_valid = 1'b0; req1_valid = 1'b0;
      end
      #1;
      if (e_err) exp_alu = {pd1, pd2, psel};
      else if (e_own == 1) exp_alu = {a1, b1, s1};
      else exp_alu = {a0, b0, s0};
      check({tag, " alu_regs"}, {alu_data1, alu_data2, alu_select}, exp_alu);
      lat = 0;
      while (!(rsp0_valid || rsp1_valid) && lat < 40) begin
         check({tag, " settle_busy_rdy"}, {busy, req1_ready, req0_ready}, 3'b100);
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, lat, e_err ? 0 : SETTLE);
      check({tag, " rsp_valid"}, {rsp1_valid, rsp0_valid}, (e_own == 1) ? 2'b10 : 2'b01);
      check({tag, " result"}, rsp_result, e_res);
      check({tag, " err"}, rsp_err, e_err);
      held = rsp_result;
      // non-owner READY must be ignored while the owner stalls
      if (e_own == 1) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      for (int k = 0; k < bp; k++) begin
         @(posedge clk); #1;
         check({tag, " stall"}, {rsp1_valid, rsp0_valid, rsp_result, rsp_err, busy, req1_ready, req0_ready},
               {(e_own == 1) ? 2'b10 : 2'b01, held, e_err, 3'b100});
      end
      rsp0_ready = (e_own == 0);
      rsp1_ready = (e_own == 1);
      @(posedge clk); #1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      check({tag, " done"}, {rsp1_valid, rsp0_valid, busy}, 3'b000);
   endtask

   typedef struct {
      bit         v0, v1;
      logic [2:0] s0; logic [7:0] a0, b0;
      logic [2:0] s1; logic [7:0] a1, b1;
      bit         hold;
      int         bp;
      int         e_own;
      logic [7:0] e_res;
      bit         e_err;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t       tbl[10];
      bit         v0, v1;
      logic [2:0] s0, s1, es;
      logic [7:0] a0, b0, a1, b1, ea, eb;
      int         own;
      bit         e_err;

      tbl[0] = '{1, 1, 3'd2, 8'h0F, 8'h3C, 3'd3, 8'h50, 8'h05, 1, 0, 0, 8'h0C, 0};
      tbl[1] = '{1, 1, 3'd2, 8'h0F, 8'h3C, 3'd3, 8'h50, 8'h05, 1, 1, 1, 8'h55, 0};
      tbl[2] = '{1, 1, 3'd2, 8'h0F, 8'h3C, 3'd3, 8'h50, 8'h05, 0, 0, 0, 8'h0C, 0};
      tbl[3] = '{1, 0, 3'd1, 8'hFF, 8'h02, 3'd0, 8'h00, 8'h00, 0, 2, 0, 8'h01, 0};
      tbl[4] = '{0, 1, 3'd0, 8'h00, 8'h00, 3'd5, 8'h33, 8'h44, 0, 0, 1, 8'h00, 1};
      tbl[5] = '{1, 1, 3'd0, 8'h12, 8'hA5, 3'd3, 8'h50, 8'h05, 1, 5, 0, 8'hA5, 0};
      tbl[6] = '{0, 1, 3'd0, 8'h00, 8'h00, 3'd3, 8'h50, 8'h05, 0, 0, 1, 8'h55, 0};
      tbl[7] = '{1, 0, 3'd7, 8'h01, 8'h02, 3'd0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 1};
      tbl[8] = '{0, 1, 3'd0, 8'h00, 8'h00, 3'd1, 8'h80, 8'h80, 0, 0, 1, 8'h00, 0};
      tbl[9] = '{1, 1, 3'd3, 8'hF0, 8'h0F, 3'd0, 8'h11, 8'h22, 0, 3, 0, 8'hFF, 0};

      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_data1 = '0; req0_data2 = '0; req0_select = '0;
      req1_data1 = '0; req1_data2 = '0; req1_select = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", all_outputs(), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of SETTLE: drop the op, no response afterwards.
      req0_valid = 1'b1; req0_select = 3'd1; req0_data1 = 8'h10; req0_data2 = 8'h20;
      #1;
      check("pre-reset grant", {req1_ready, req0_ready}, 2'b01);
      @(posedge clk); #1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      check("pre-reset busy", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("mid-run reset outputs", all_outputs(), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("post-reset grant", {req1_ready, req0_ready}, 2'b01);
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int k = 0; k < SETTLE + 3; k++) begin
         @(posedge clk); #1;
         check("no stale response", {rsp1_valid, rsp0_valid, busy}, 3'b000);
      end
      model_last = 1;

      for (int i = 0; i < 10; i++) begin
         round($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1,
               tbl[i].s0, tbl[i].a0, tbl[i].b0, tbl[i].s1, tbl[i].a1, tbl[i].b1,
               tbl[i].hold, tbl[i].bp, tbl[i].e_own, tbl[i].e_res, tbl[i].e_err);
         model_last = tbl[i].e_own;
      end

      for (int i = 0; i < 40; i++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         s0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = 8'($urandom);
         s1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = 8'($urandom);
         if (v0 && v1) own = (model_last == 1) ? 0 : 1;
         else own = v1 ? 1 : 0;
         es = (own == 1) ? s1 : s0;
         ea = (own == 1) ? a1 : a0;
         eb = (own == 1) ? b1 : b0;
         e_err = (es >= 3'd4);
         round($sformatf("rnd%0d", i), v0, v1, s0, a0, b0, s1, a1, b1,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               own, e_err ? 8'h00 : ref_alu(es, ea, eb), e_err);
         model_last = own;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
